mac_engine: RTL and testbench

Parametrised multiply-accumulate engine. It is the successor to the fixed 8-bit MAC datapath: a single block holds the operand capture, a sequential shift-add multiplier, the accumulator and the adder behind one valid/ready handshake. It adds generic operand and accumulator widths, a per-operation accumulator clear, an optional saturation mode, a sticky overflow flag and a count of accumulated products. It sits between an operand source (FIFO or controller) and any consumer of the running sum.

---
 rtl/mac_engine.sv | 118 +++++++++++
 tb/tb_mac_engine.sv | 228 ++++++++++++++++++++++
 2 files changed

// File: rtl/mac_engine.sv
// Multiply-accumulate engine: operands captured on a valid/ready handshake, shift-add
// multiply over DATA_W cycles, then one accumulate cycle with optional saturation.
module mac_engine #(
    parameter int unsigned DATA_W = 8,
    parameter int unsigned ACC_W  = 2 * DATA_W + 4,
    parameter int unsigned CNT_W  = 8,
    parameter bit          SAT    = 1'b1
) (
    input  logic              clk,
    input  logic              rst,
    input  logic              in_valid,
    output logic              in_ready,
    input  logic [DATA_W-1:0] a_in,
    input  logic [DATA_W-1:0] b_in,
    input  logic              acc_clr,
    output logic              busy,
    output logic              out_valid,
    output logic [ACC_W-1:0]  acc_out,
    output logic              ovf,
    output logic [CNT_W-1:0]  acc_cnt
);

    localparam int unsigned BIT_W = $clog2(DATA_W);
    localparam int unsigned PROD_W = 2 * DATA_W;
    localparam logic [BIT_W-1:0] LAST_BIT = BIT_W'(DATA_W - 1);

    typedef enum logic [1:0] {
        S_IDLE,
        S_MUL,
        S_ACC
    } state_t;

    state_t state, state_next;

    logic [DATA_W-1:0] a_reg;
    logic [DATA_W-1:0] b_reg;
    logic              clr_reg;
    logic [PROD_W-1:0] prod;
    logic [PROD_W-1:0] partial;
    logic [BIT_W-1:0]  bit_idx;
    logic [ACC_W:0]    sum;

    always_ff @(posedge clk) begin
        if (!rst) begin
            state <= S_IDLE;
        end else begin
            state <= state_next;
        end
    end

    always_comb begin
        state_next = state;
        case (state)
            S_IDLE:  if (in_valid) state_next = S_MUL;
            S_MUL:   if (bit_idx == LAST_BIT) state_next = S_ACC;
            S_ACC:   state_next = S_IDLE;
            default: state_next = S_IDLE;
        endcase
    end

    // Shifted multiplicand for the current multiplier bit; carry lands in sum[ACC_W].
    always_comb begin
        partial = PROD_W'(a_reg) << bit_idx;
        sum     = {1'b0, acc_out} + (ACC_W + 1)'(prod);
    end

    assign in_ready = (state == S_IDLE);
    assign busy     = ~in_ready;

    always_ff @(posedge clk) begin
        if (!rst) begin
            a_reg     <= '0;
            b_reg     <= '0;
            clr_reg   <= 1'b0;
            prod      <= '0;
            bit_idx   <= '0;
            out_valid <= 1'b0;
            acc_out   <= '0;
            ovf       <= 1'b0;
            acc_cnt   <= '0;
        end else begin
            out_valid <= 1'b0;
            case (state)
                S_IDLE: begin
                    if (in_valid) begin
                        a_reg   <= a_in;
                        b_reg   <= b_in;
                        clr_reg <= acc_clr;
                        prod    <= '0;
                        bit_idx <= '0;
                    end
                end
                S_MUL: begin
                    if (b_reg[bit_idx]) prod <= prod + partial;
                    bit_idx <= bit_idx + 1'b1;
                end
                S_ACC: begin
                    out_valid <= 1'b1;
                    if (clr_reg) begin
                        acc_out <= ACC_W'(prod);
                        ovf     <= 1'b0;
                        acc_cnt <= CNT_W'(1);
                    end else begin
                        if (sum[ACC_W]) begin
                            acc_out <= SAT ? '1 : sum[ACC_W-1:0];
                            ovf     <= 1'b1;
                        end else begin
                            acc_out <= sum[ACC_W-1:0];
                        end
                        if (acc_cnt != '1) acc_cnt <= acc_cnt + 1'b1;
                    end
                end
                default: ;
            endcase
        end
    end

endmodule

// File: tb/tb_mac_engine.sv
// Bench for mac_engine: saturating and wrapping instances share stimulus and are
// checked every cycle against an arithmetic model plus hand-computed values.
module tb_mac_engine;

    localparam int unsigned DATA_W = 8;
    localparam int unsigned ACC_W  = 20;
    localparam int unsigned CNT_W  = 8;
    localparam longint ACC_MAX = (64'd1 << ACC_W) - 1;
    localparam longint CNT_MAX = (64'd1 << CNT_W) - 1;

    logic clk = 1'b0;
    logic rst = 1'b0;
    logic in_valid = 1'b0;
    logic [DATA_W-1:0] a_in = '0;
    logic [DATA_W-1:0] b_in = '0;
    logic acc_clr = 1'b0;

    logic              rdy_s, busy_s, ov_s, ovf_s;
    logic [ACC_W-1:0]  acc_s;
    logic [CNT_W-1:0]  cnt_s;
    logic              rdy_w, busy_w, ov_w, ovf_w;
    logic [ACC_W-1:0]  acc_w;
    logic [CNT_W-1:0]  cnt_w;

    int checks = 0;
    int errors = 0;
    bit chk_en = 1'b0;

    always #5 clk = ~clk;

    mac_engine #(.DATA_W(DATA_W), .ACC_W(ACC_W), .CNT_W(CNT_W), .SAT(1'b1)) dut_sat (
        .clk(clk), .rst(rst), .in_valid(in_valid), .in_ready(rdy_s),
        .a_in(a_in), .b_in(b_in), .acc_clr(acc_clr), .busy(busy_s),
        .out_valid(ov_s), .acc_out(acc_s), .ovf(ovf_s), .acc_cnt(cnt_s)
    );

    mac_engine #(.DATA_W(DATA_W), .ACC_W(ACC_W), .CNT_W(CNT_W), .SAT(1'b0)) dut_wrap (
        .clk(clk), .rst(rst), .in_valid(in_valid), .in_ready(rdy_w),
        .a_in(a_in), .b_in(b_in), .acc_clr(acc_clr), .busy(busy_w),
        .out_valid(ov_w), .acc_out(acc_w), .ovf(ovf_w), .acc_cnt(cnt_w)
    );

    task automatic chk(input string name, input longint act, input longint exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got %0d expected %0d at %0t", name, act, exp, $time);
        end
    endtask

    // Model: an operation taken at an edge completes DATA_W+1 edges later.
    int     m_timer = 0;
    bit     m_valid = 1'b0;
    longint m_a = 0, m_b = 0;
    bit     m_clr = 1'b0;
    longint m_acc[2];
    bit     m_ovf[2];
    longint m_cnt[2];

    always @(posedge clk) begin
        m_valid = 1'b0;
        if (!rst) begin
            m_timer = 0;
            for (int i = 0; i < 2; i++) begin
                m_acc[i] = 0; m_ovf[i] = 1'b0; m_cnt[i] = 0;
            end
        end else if (m_timer > 0) begin
            m_timer--;
            if (m_timer == 0) begin
                m_valid = 1'b1;
                for (int i = 0; i < 2; i++) begin
                    longint p, s;
                    p = m_a * m_b;
                    if (m_clr) begin
                        m_acc[i] = p; m_ovf[i] = 1'b0; m_cnt[i] = 1;
                    end else begin
                        s = m_acc[i] + p;
                        if (s > ACC_MAX) begin
                            m_ovf[i] = 1'b1;
                            m_acc[i] = (i == 0) ? ACC_MAX : s % (ACC_MAX + 1);
                        end else begin
                            m_acc[i] = s;
                        end
                        if (m_cnt[i] < CNT_MAX) m_cnt[i]++;
                    end
                end
            end
        end else if (in_valid) begin
            m_a = a_in; m_b = b_in; m_clr = acc_clr;
            m_timer = DATA_W + 1;
        end
    end

    always @(negedge clk) begin
        if (chk_en) begin
            chk("sat.in_ready", rdy_s, m_timer == 0);
            chk("sat.busy", busy_s, m_timer != 0);
            chk("sat.out_valid", ov_s, m_valid);
            chk("sat.acc_out", acc_s, m_acc[0]);
            chk("sat.ovf", ovf_s, m_ovf[0]);
            chk("sat.acc_cnt", cnt_s, m_cnt[0]);
            chk("wrap.in_ready", rdy_w, m_timer == 0);
            chk("wrap.out_valid", ov_w, m_valid);
            chk("wrap.acc_out", acc_w, m_acc[1]);
            chk("wrap.ovf", ovf_w, m_ovf[1]);
            chk("wrap.acc_cnt", cnt_w, m_cnt[1]);
        end
    end

    int lat;

    // Present one operand pair, then wait (bounded) for the result pulse.
    task automatic do_op(input int a, input int b, input bit clr, input bit toggle);
        bit seen;
        @(negedge clk);
        a_in = DATA_W'(a); b_in = DATA_W'(b); acc_clr = clr; in_valid = 1'b1;
        @(posedge clk);
        #1 in_valid = 1'b0;
        seen = 1'b0;
        lat = 0;
        for (int n = 1; n <= 20 && !seen; n++) begin
            @(negedge clk);
            if (ov_s) begin
                seen = 1'b1;
                lat = n;
            end
            if (toggle && n <= DATA_W) begin
                in_valid = ~in_valid; a_in = ~a_in; b_in = ~b_in; acc_clr = ~acc_clr;
            end else begin
                in_valid = 1'b0;
            end
        end
        if (!seen) chk("op_timeout", 0, 1);
    endtask

    initial begin
        int pulses, last, bad_gap;
        rst = 1'b0;
        repeat (3) @(negedge clk);
        rst = 1'b1;
        chk_en = 1'b1;
        @(negedge clk);
        chk("reset.acc", acc_s, 0);
        chk("reset.ovf", ovf_s, 0);
        chk("reset.cnt", cnt_s, 0);
        chk("reset.out_valid", ov_s, 0);
        chk("reset.in_ready", rdy_s, 1);

        do_op(12, 10, 1'b1, 1'b0);
        chk("clr.latency", lat, DATA_W + 2);
        chk("clr.in_ready_with_valid", rdy_s, 1);
        chk("clr.acc", acc_s, 120);
        chk("clr.cnt", cnt_s, 1);
        do_op(3, 5, 1'b0, 1'b0);
        chk("add.acc", acc_s, 135);
        chk("add.cnt", cnt_s, 2);

        do_op(255, 255, 1'b1, 1'b0);
        for (int k = 0; k < 15; k++) do_op(255, 255, 1'b0, 1'b0);
        chk("sat16.acc", acc_s, 1040400);
        chk("sat16.ovf", ovf_s, 0);
        chk("wrap16.acc", acc_w, 1040400);
        do_op(255, 255, 1'b0, 1'b0);
        chk("sat17.acc", acc_s, 1048575);
        chk("sat17.ovf", ovf_s, 1);
        chk("sat17.cnt", cnt_s, 17);
        chk("wrap17.acc", acc_w, 56849);
        chk("wrap17.ovf", ovf_w, 1);
        do_op(255, 255, 1'b0, 1'b0);
        chk("sat_hold.acc", acc_s, 1048575);
        do_op(1, 1, 1'b1, 1'b0);
        chk("reclr.acc", acc_s, 1);
        chk("reclr.ovf", ovf_s, 0);
        chk("reclr.wrap_ovf", ovf_w, 0);

        do_op(7, 9, 1'b0, 1'b1);
        chk("busy.acc", acc_s, 64);
        chk("busy.cnt", cnt_s, 2);
        repeat (12) @(negedge clk);
        chk("busy.no_extra", acc_s, 64);

        @(negedge clk);
        a_in = 8'd5; b_in = 8'd5; acc_clr = 1'b0; in_valid = 1'b1;
        @(posedge clk);
        #1 in_valid = 1'b0;
        repeat (4) @(negedge clk);
        rst = 1'b0;
        @(negedge clk);
        rst = 1'b1;
        chk("abort.out_valid", ov_s, 0);
        chk("abort.acc", acc_s, 0);
        chk("abort.in_ready", rdy_s, 1);
        repeat (10) @(negedge clk);
        do_op(2, 2, 1'b0, 1'b0);
        chk("abort_next.acc", acc_s, 4);
        chk("abort_next.cnt", cnt_s, 1);

        @(negedge clk);
        a_in = 8'd0; b_in = 8'd255; acc_clr = 1'b0; in_valid = 1'b1;
        pulses = 0; last = -1; bad_gap = 0;
        for (int n = 0; n < 2620; n++) begin
            @(negedge clk);
            if (ov_s) begin
                if (last >= 0 && n - last != DATA_W + 2) bad_gap++;
                last = n;
                pulses++;
            end
        end
        in_valid = 1'b0;
        for (int n = 0; n < 20 && !rdy_s; n++) @(negedge clk);
        repeat (2) @(negedge clk);
        chk("b2b.bad_gaps", bad_gap, 0);
        chk("b2b.pulses", pulses, 262);
        chk("b2b.acc", acc_s, 4);
        chk("b2b.cnt", cnt_s, 255);

        chk_en = 1'b0;
        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

    initial begin
        #200000;
        $display("FAIL watchdog: got timeout expected completion");
        $fatal(1, "timeout");
    end

endmodule
